avalon_st_dsp_path: RTL and testbench
=====================================

# avalon_st_dsp_path

Parametrised Avalon-ST processing path that succeeds the fixed 16-bit FIR/bypass stream mux in the SoC top level. It accepts sink beats and routes each packet either straight through (bypass) or through an external fixed-latency DSP core (processed). The core sees optional byte reversal on both sides. An output FIFO sits in front of the source, with credit-based backpressure, so the source can stall without ever stalling the core. Mode changes take effect only at packet boundaries and after the pipeline drains, so beats are never reordered or split across modes.

## Interface
Parameters:
- DATA_W, 16, beat width; multiple of 8.
- FIFO_DEPTH, 8, output FIFO entries; power of 2, >= PROC_LATENCY+2.
- PROC_LATENCY, 4, fixed cycles from proc_valid to proc_result_valid; >= 1.
- SWAP_BYTES, 1, 1 = reverse byte order into and out of the core; bypass path is never swapped.

Ports:
- clk  in  1  the single clock; everything is synchronous to it.
- rst_n  in  1  reset; synchronous and active-low.
- cfg_enable  in  1  requested mode: 1 = processed, 0 = bypass.
- status_clear  in  1  single-cycle pulse; clears pkt_count and the sticky error flags.
- snk_data  in  DATA_W  sink beat data.
- snk_valid, snk_sop, snk_eop  in  1 each  sink beat qualifiers.
- snk_ready  out  1  sink ready, ready latency 0.
- src_data  out  DATA_W  source beat data.
- src_valid, src_sop, src_eop  out  1 each  source beat qualifiers.
- src_ready  in  1  source ready.
- proc_data  out  DATA_W  registered beat to the DSP core.
- proc_valid  out  1  qualifies proc_data.
- proc_result  in  DATA_W  DSP core output.
- proc_result_valid  in  1  qualifies proc_result.
- active_mode  out  1  mode of the packet currently in progress.
- pkt_count  out  16  count of packets completed on the source; wraps.
- err_framing, err_latency  out  1 each  sticky error flags.

## Operation
- Accept: a beat is accepted when snk_valid && snk_ready.
- Framing FSM has two states, IDLE and IN_PKT.
  - IDLE -> IN_PKT on an accepted sop beat without eop. active_mode <= cfg_enable on that beat.
  - IN_PKT -> IDLE on an accepted eop beat.
  - A single-beat packet (sop && eop) stays in IDLE but still loads active_mode.
  - Per-beat mode: cfg_enable in IDLE, active_mode in IN_PKT.
- Framing errors:
  - A beat accepted in IDLE without sop is forwarded as a bypass-of-current-cfg beat and sets err_framing.
  - A sop accepted while in IN_PKT sets err_framing and restarts the packet; active_mode is not reloaded.
- Drain rule: in IDLE, snk_ready = 0 while cfg_enable != active_mode and inflight != 0.
- Credits: snk_ready = !drain_block && (fifo_count + inflight) < FIFO_DEPTH. inflight counts beats issued to the core whose result is not yet written.
- Bypass beat: written to the FIFO on the acceptance cycle, with data, sop and eop.
- Processed beat:
  - proc_data <= swap(snk_data) and proc_valid <= 1 on acceptance.
  - sop and eop travel in a PROC_LATENCY-deep delay line alongside proc_valid.
  - When the delay line output is valid, swap(proc_result) is written to the FIFO with the delayed sop and eop.
- Latency check:
  - proc_result_valid must equal the delay line valid output every cycle.
  - On mismatch, set err_latency. The FIFO write follows the delay line only; a stray result is dropped.
- Source: FIFO is show-ahead. src_valid = !empty, and src_* come from the head entry. Pop on src_valid && src_ready.
- pkt_count: +1 on a source handshake with src_eop. Wraps 0xFFFF -> 0.
- status_clear: has priority over a same-cycle increment or error set. Result is 0 and both flags clear.
- Byte swap: byte i of DATA_W maps to byte (DATA_W/8-1-i).

## Timing
- While rst_n = 0, on the next edge:
  - FIFO empty, delay line cleared, inflight = 0, state IDLE.
  - active_mode = 0, pkt_count = 0, err flags = 0.
  - proc_valid = 0, proc_data = 0, src_valid = 0.
  - snk_ready is forced 0 while rst_n is low.
- Reset mid-packet discards all buffered and in-flight beats. No partial packet appears after reset.
- Bypass latency: accepted on cycle N -> src_valid on cycle N+1, if the FIFO was empty.
- Processed latency:
  - proc_valid on N+1.
  - Result expected on N+1+PROC_LATENCY.
  - src_valid on N+2+PROC_LATENCY.
- Full FIFO: a same-cycle pop and write are both honoured, and fifo_count is unchanged.
- The credit scheme guarantees no delay line write ever finds the FIFO full.
- Counters: inflight and fifo_count are $clog2(FIFO_DEPTH)+1 bits wide.
- Throughput: 1 beat/cycle sustained in both modes when src_ready = 1.

## Test plan
- Bypass streaming: cfg_enable=0, 4-beat packet 0x1122..0x4455, src_ready=1 -> identical data on the source 1 cycle later, sop and eop preserved, pkt_count=1.
- Processed path: cfg_enable=1, SWAP_BYTES=1, core model = identity with latency 4, beat 0x1234 -> proc_data=0x3412, src_data=0x1234 at N+6.
- Mode switch: toggle cfg_enable mid-packet -> the packet stays in its mode. Next sop is held (snk_ready=0) until inflight=0, then the new mode applies, with no reordering.
- Backpressure: src_ready=0, continuous sink -> snk_ready drops exactly when fifo_count+inflight=FIFO_DEPTH. No beat is lost or duplicated after src_ready returns.
- Errors: orphan non-sop beat -> err_framing=1. Core asserts a result 1 cycle late -> err_latency=1. status_clear pulse -> flags and pkt_count = 0.
- Reset mid-packet: rst_n low for 1 cycle during a processed packet -> src_valid=0 next cycle, and the FIFO stays empty until new sink input.

Source files
------------

// File: rtl/avalon_st_dsp_path.sv
// Avalon-ST processing path. Each packet is routed either straight to the
// output FIFO (bypass) or through an external fixed-latency DSP core
// (processed). The mode is latched at packet start, and it only changes once
// the core has drained. Credit-based sink backpressure guarantees that core
// results always find room in the output FIFO, so the core never stalls.
module avalon_st_dsp_path #(
    parameter int DATA_W       = 16,
    parameter int FIFO_DEPTH   = 8,
    parameter int PROC_LATENCY = 4,
    parameter int SWAP_BYTES   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_enable,
    input  logic              status_clear,
    input  logic [DATA_W-1:0] snk_data,
    input  logic              snk_valid,
    input  logic              snk_sop,
    input  logic              snk_eop,
    output logic              snk_ready,
    output logic [DATA_W-1:0] src_data,
    output logic              src_valid,
    output logic              src_sop,
    output logic              src_eop,
    input  logic              src_ready,
    output logic [DATA_W-1:0] proc_data,
    output logic              proc_valid,
    input  logic [DATA_W-1:0] proc_result,
    input  logic              proc_result_valid,
    output logic              active_mode,
    output logic [15:0]       pkt_count,
    output logic              err_framing,
    output logic              err_latency
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int NB = DATA_W / 8;
    localparam logic [CW:0] LP_DEPTH = (CW+1)'(FIFO_DEPTH);

    typedef enum logic {ST_IDLE, ST_IN_PKT} state_t;

    // Reverse byte order when swapping is enabled; identity otherwise.
    function automatic logic [DATA_W-1:0] f_swap(input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] r;
        r = d;
        if (SWAP_BYTES != 0) begin
            for (int i = 0; i < NB; i++) r[8*i +: 8] = d[8*(NB-1-i) +: 8];
        end
        return r;
    endfunction

    state_t              r_state, w_state_next;
    logic                r_active_mode;
    logic [CW-1:0]       r_inflight, r_fifo_count;
    logic [AW-1:0]       r_wr_ptr, r_rd_ptr;
    logic [DATA_W+1:0]   r_mem [FIFO_DEPTH];  // {sop, eop, data}
    logic                r_proc_valid, r_proc_sop, r_proc_eop;
    logic [DATA_W-1:0]   r_proc_data;
    logic [PROC_LATENCY-1:0] r_dl_valid, r_dl_sop, r_dl_eop;
    logic [15:0]         r_pkt_count;
    logic                r_err_framing, r_err_latency;

    logic                w_drain_block, w_credit_ok, w_accept, w_beat_mode;
    logic                w_proc_issue, w_byp_wr, w_fifo_wr, w_pop, w_framing_err;
    logic                w_dl_valid, w_dl_sop, w_dl_eop;
    logic [CW:0]         w_occupancy;
    logic [DATA_W+1:0]   w_fifo_wdata, w_head;

    // Sink credit: everything buffered or still inside the core counts.
    assign w_occupancy   = {1'b0, r_fifo_count} + {1'b0, r_inflight};
    assign w_credit_ok   = w_occupancy < LP_DEPTH;
    assign w_drain_block = (r_state == ST_IDLE) && (cfg_enable != r_active_mode)
                           && (r_inflight != '0);
    assign snk_ready     = rst_n && !w_drain_block && w_credit_ok;
    assign w_accept      = snk_valid && snk_ready;

    assign w_dl_valid = r_dl_valid[PROC_LATENCY-1];
    assign w_dl_sop   = r_dl_sop[PROC_LATENCY-1];
    assign w_dl_eop   = r_dl_eop[PROC_LATENCY-1];

    // Framing next state, per-beat routing and framing-error detection.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    always_comb begin
        w_state_next  = r_state;
        w_beat_mode   = cfg_enable;
        w_framing_err = 1'b0;
        if (r_state == ST_IN_PKT) w_beat_mode = r_active_mode;
        if (w_accept) begin
            if (r_state == ST_IDLE) begin
                if (snk_sop && !snk_eop) w_state_next = ST_IN_PKT;
                if (!snk_sop)            w_framing_err = 1'b1;
            end else begin
                if (snk_sop) w_framing_err = 1'b1;
                if (snk_eop) w_state_next  = ST_IDLE;
            end
        end
    end

    assign w_proc_issue = w_accept && w_beat_mode;
    assign w_byp_wr     = w_accept && !w_beat_mode;
    assign w_fifo_wr    = w_dl_valid || w_byp_wr;
    assign w_fifo_wdata = w_dl_valid ? {w_dl_sop, w_dl_eop, f_swap(proc_result)}
                                     : {snk_sop, snk_eop, snk_data};

    assign w_head    = r_mem[r_rd_ptr];
    assign src_valid = (r_fifo_count != '0);
    assign src_data  = w_head[DATA_W-1:0];
    assign src_eop   = w_head[DATA_W];
    assign src_sop   = w_head[DATA_W+1];
    assign w_pop     = src_valid && src_ready;

    // Framing state and the mode latched at packet start.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_active_mode <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept && (r_state == ST_IDLE) && snk_sop) r_active_mode <= cfg_enable;
        end
    end

    // Core issue register and the sop/eop/valid delay line matching core latency.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_proc_valid <= 1'b0;
            r_proc_data  <= '0;
            r_proc_sop   <= 1'b0;
            r_proc_eop   <= 1'b0;
            r_dl_valid   <= '0;
            r_dl_sop     <= '0;
            r_dl_eop     <= '0;
        end else begin
            r_proc_valid <= w_proc_issue;
            if (w_proc_issue) begin
                r_proc_data <= f_swap(snk_data);
                r_proc_sop  <= snk_sop;
                r_proc_eop  <= snk_eop;
            end
            for (int i = PROC_LATENCY - 1; i > 0; i--) begin
                r_dl_valid[i] <= r_dl_valid[i-1];
                r_dl_sop[i]   <= r_dl_sop[i-1];
                r_dl_eop[i]   <= r_dl_eop[i-1];
            end
            r_dl_valid[0] <= r_proc_valid;
            r_dl_sop[0]   <= r_proc_sop;
            r_dl_eop[0]   <= r_proc_eop;
        end
    end

    // FIFO pointers, occupancy and in-flight core beat count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_fifo_count <= '0;
            r_inflight   <= '0;
        end else begin
            if (w_fifo_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
            r_fifo_count <= r_fifo_count + CW'(w_fifo_wr) - CW'(w_pop);
            r_inflight   <= r_inflight + CW'(w_proc_issue) - CW'(w_dl_valid);
        end
    end

    // FIFO storage; contents are don't-care until the count marks them valid.
    // NOTE: the memory array has no reset; only the pointers and count need one.
    always_ff @(posedge clk) begin
        if (w_fifo_wr) r_mem[r_wr_ptr] <= w_fifo_wdata;
    end

    // Packet counter and sticky error flags; clear wins over set/increment.
    always_ff @(posedge clk) begin
        if (!rst_n || status_clear) begin
            r_pkt_count   <= '0;
            r_err_framing <= 1'b0;
            r_err_latency <= 1'b0;
        end else begin
            if (w_pop && src_eop)                   r_pkt_count   <= r_pkt_count + 16'd1;
            if (w_framing_err)                      r_err_framing <= 1'b1;
            if (proc_result_valid != w_dl_valid)    r_err_latency <= 1'b1;
        end
    end

    assign proc_valid  = r_proc_valid;
    assign proc_data   = r_proc_data;
    assign active_mode = r_active_mode;
    assign pkt_count   = r_pkt_count;
    assign err_framing = r_err_framing;
    assign err_latency = r_err_latency;

endmodule

// File: tb/tb_avalon_st_dsp_path.sv
// Bench for avalon_st_dsp_path: directed steps plus random packets checked
// against a transaction-level model (in-order scoreboard with landing times).
module tb_avalon_st_dsp_path;

    localparam int DATA_W       = 16;
    localparam int FIFO_DEPTH   = 8;
    localparam int PROC_LATENCY = 4;
    localparam int SWAP_BYTES   = 1;

    logic              clk, rst_n, cfg_enable, status_clear;
    logic [DATA_W-1:0] snk_data, src_data, proc_data, proc_result;
    logic              snk_valid, snk_sop, snk_eop, snk_ready;
    logic              src_valid, src_sop, src_eop, src_ready;
    logic              proc_valid, proc_result_valid;
    logic              active_mode, err_framing, err_latency;
    logic [15:0]       pkt_count;

    avalon_st_dsp_path #(
        .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH),
        .PROC_LATENCY(PROC_LATENCY), .SWAP_BYTES(SWAP_BYTES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_enable(cfg_enable), .status_clear(status_clear),
        .snk_data(snk_data), .snk_valid(snk_valid), .snk_sop(snk_sop), .snk_eop(snk_eop),
        .snk_ready(snk_ready),
        .src_data(src_data), .src_valid(src_valid), .src_sop(src_sop), .src_eop(src_eop),
        .src_ready(src_ready),
        .proc_data(proc_data), .proc_valid(proc_valid),
        .proc_result(proc_result), .proc_result_valid(proc_result_valid),
        .active_mode(active_mode), .pkt_count(pkt_count),
        .err_framing(err_framing), .err_latency(err_latency)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Identity DSP core with fixed latency; late_mode delays only the valid.
    logic [DATA_W-1:0] core_d [PROC_LATENCY];
    logic              core_v [PROC_LATENCY+1];
    logic              late_mode;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i <= PROC_LATENCY; i++) core_v[i] <= 1'b0;
        end else begin
            core_v[0] <= proc_valid;
            core_d[0] <= proc_data;
            for (int i = 1; i <= PROC_LATENCY; i++) core_v[i] <= core_v[i-1];
            for (int i = 1; i < PROC_LATENCY; i++)  core_d[i] <= core_d[i-1];
        end
    end

    assign proc_result       = core_d[PROC_LATENCY-1];
    assign proc_result_valid = late_mode ? core_v[PROC_LATENCY] : core_v[PROC_LATENCY-1];

    // Reference model: expected output beats in order, each with the cycle
    // at which it becomes visible on the source.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              sop;
        logic              eop;
        logic              proc;
        int                land;
    } beat_t;

    beat_t             sb[$];
    logic              m_in_pkt, m_active, m_errf, m_pv;
    logic [DATA_W-1:0] m_pd;
    logic [15:0]       m_pkt;
    int                t, ready_pct;
    int                n_vec, n_err;

    function automatic logic [DATA_W-1:0] ref_swap(input logic [DATA_W-1:0] d);
        return (SWAP_BYTES != 0) ? {<<8{d}} : d;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_in_pkt = 1'b0;
        m_active = 1'b0;
        m_errf   = 1'b0;
        m_pv     = 1'b0;
        m_pd     = '0;
        m_pkt    = '0;
    endtask

    // One clock cycle: randomize src_ready, compare at the negedge, update model.
    task automatic cycle(output logic acc);
        int    inflight;
        logic  exp_rdy, exp_sv, mode, nxt_pv;
        beat_t b;
        src_ready = (int'($urandom_range(99)) < ready_pct);
        acc    = 1'b0;
        nxt_pv = 1'b0;
        @(negedge clk);
        check("active_mode", 32'(active_mode), 32'(m_active));
        check("pkt_count",   32'(pkt_count),   32'(m_pkt));
        check("err_framing", 32'(err_framing), 32'(m_errf));
        check("proc_valid",  32'(proc_valid),  32'(m_pv));
        if (m_pv) check("proc_data", 32'(proc_data), 32'(m_pd));
        if (!rst_n) begin
            check("snk_ready_in_reset", 32'(snk_ready), 0);
            model_reset();
        end else begin
            inflight = 0;
            foreach (sb[i]) if (sb[i].proc && sb[i].land > t) inflight++;
            exp_rdy = !(!m_in_pkt && (cfg_enable != m_active) && inflight != 0)
                      && (sb.size() < FIFO_DEPTH);
            check("snk_ready", 32'(snk_ready), 32'(exp_rdy));
            exp_sv = (sb.size() != 0) && (sb[0].land <= t);
            check("src_valid", 32'(src_valid), 32'(exp_sv));
            if (src_valid && src_ready && exp_sv) begin
                b = sb.pop_front();
                check("src_data", 32'(src_data), 32'(b.data));
                check("src_sop",  32'(src_sop),  32'(b.sop));
                check("src_eop",  32'(src_eop),  32'(b.eop));
                if (b.eop) m_pkt = m_pkt + 16'd1;
            end
            if (snk_valid && snk_ready) begin
                acc  = 1'b1;
                mode = m_in_pkt ? m_active : cfg_enable;
                if (!m_in_pkt) begin
                    if (snk_sop) begin
                        m_active = cfg_enable;
                        if (!snk_eop) m_in_pkt = 1'b1;
                    end else m_errf = 1'b1;
                end else begin
                    if (snk_sop) m_errf = 1'b1;
                    if (snk_eop) m_in_pkt = 1'b0;
                end
                b.data = snk_data;
                b.sop  = snk_sop;
                b.eop  = snk_eop;
                b.proc = mode;
                b.land = mode ? t + PROC_LATENCY + 2 : t + 1;
                sb.push_back(b);
                nxt_pv = mode;
                if (mode) m_pd = ref_swap(snk_data);
            end
            if (status_clear) begin
                m_pkt  = '0;
                m_errf = 1'b0;
            end
        end
        m_pv = nxt_pv;
        @(posedge clk);
        #1;
        t++;
    endtask

    // Present one beat and hold it until accepted (bounded); leaves valid high.
    task automatic send_beat(input logic [DATA_W-1:0] d, input logic sop, input logic eop,
                             output int waited);
        logic acc;
        snk_valid = 1'b1;
        snk_data  = d;
        snk_sop   = sop;
        snk_eop   = eop;
        waited    = 0;
        acc       = 1'b0;
        while (!acc && waited < 300) begin
            cycle(acc);
            if (!acc) waited++;
        end
        check("sink_accept", 32'(acc), 1);
    endtask

    task automatic idle(input int n);
        logic acc;
        snk_valid = 1'b0;
        repeat (n) cycle(acc);
    endtask

    task automatic send_pkt(input int len, input int gap_pct);
        int   w;
        logic acc;
        for (int i = 0; i < len; i++) begin
            if (int'($urandom_range(99)) < gap_pct) begin
                snk_valid = 1'b0;
                cycle(acc);
            end
            send_beat(DATA_W'($urandom), i == 0, i == len - 1, w);
        end
        snk_valid = 1'b0;
    endtask

    task automatic drain();
        int   n;
        logic acc;
        snk_valid = 1'b0;
        ready_pct = 100;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            cycle(acc);
            n++;
        end
        check("drain_empty", sb.size(), 0);
        repeat (3) cycle(acc);
    endtask

    initial begin
        int                w, idx;
        logic              acc;
        logic [DATA_W-1:0] bp_data [12];

        n_vec = 0;  n_err = 0;  t = 0;  ready_pct = 100;
        late_mode = 1'b0;
        rst_n = 1'b0;  cfg_enable = 1'b0;  status_clear = 1'b0;
        snk_valid = 1'b0;  snk_sop = 1'b0;  snk_eop = 1'b0;  snk_data = '0;
        src_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check("rst_src_valid",   32'(src_valid),   0);
        check("rst_proc_valid",  32'(proc_valid),  0);
        check("rst_proc_data",   32'(proc_data),   0);
        check("rst_pkt_count",   32'(pkt_count),   0);
        check("rst_active_mode", 32'(active_mode), 0);
        check("rst_err_framing", 32'(err_framing), 0);
        check("rst_err_latency", 32'(err_latency), 0);
        check("rst_snk_ready",   32'(snk_ready),   0);
        rst_n = 1'b1;
        idle(2);

        // Bypass streaming: 4-beat packet, visible one cycle after acceptance
        cfg_enable = 1'b0;
        send_beat(16'h1122, 1'b1, 1'b0, w);
        check("byp_lat_valid", 32'(src_valid), 1);
        check("byp_lat_data",  32'(src_data),  32'h1122);
        check("byp_lat_sop",   32'(src_sop),   1);
        send_beat(16'h2233, 1'b0, 1'b0, w);
        send_beat(16'h3344, 1'b0, 1'b0, w);
        send_beat(16'h4455, 1'b0, 1'b1, w);
        drain();
        check("byp_pkt_count", 32'(pkt_count), 1);

        // Processed path: 0x1234 -> core sees 0x3412, source shows 0x1234 at N+6
        cfg_enable = 1'b1;
        send_beat(16'h1234, 1'b1, 1'b1, w);
        snk_valid = 1'b0;
        check("proc_issue_valid", 32'(proc_valid), 1);
        check("proc_issue_data",  32'(proc_data),  32'h3412);
        repeat (4) cycle(acc);
        check("proc_src_early", 32'(src_valid), 0);
        cycle(acc);
        check("proc_src_valid", 32'(src_valid), 1);
        check("proc_src_data",  32'(src_data),  32'h1234);
        drain();

        // Mode switch mid-packet; next sop held until the core drains
        cfg_enable = 1'b1;
        send_beat(16'hA1A1, 1'b1, 1'b0, w);
        send_beat(16'hA2A2, 1'b0, 1'b0, w);
        cfg_enable = 1'b0;
        send_beat(16'hA3A3, 1'b0, 1'b0, w);
        send_beat(16'hA4A4, 1'b0, 1'b1, w);
        send_beat(16'hB1B1, 1'b1, 1'b1, w);
        check("mode_switch_held", 32'(w > 0), 1);
        drain();
        check("mode_switch_active", 32'(active_mode), 0);

        // Backpressure in both modes: exactly FIFO_DEPTH beats taken while stalled
        for (int m = 1; m >= 0; m--) begin
            cfg_enable = 1'(m);
            for (int i = 0; i < 12; i++) bp_data[i] = DATA_W'($urandom);
            ready_pct = 0;
            idx = 0;
            for (int c = 0; c < 20; c++) begin
                snk_valid = 1'b1;
                snk_data  = bp_data[idx];
                snk_sop   = (idx == 0);
                snk_eop   = (idx == 11);
                cycle(acc);
                if (acc) idx++;
            end
            check("bp_accepted", idx, FIFO_DEPTH);
            ready_pct = 100;
            for (int c = 0; c < 100 && idx < 12; c++) begin
                snk_valid = 1'b1;
                snk_data  = bp_data[idx];
                snk_sop   = (idx == 0);
                snk_eop   = (idx == 11);
                cycle(acc);
                if (acc) idx++;
            end
            check("bp_all_sent", idx, 12);
            drain();
        end

        // Random packets, random modes, random source stalls
        for (int p = 0; p < 40; p++) begin
            cfg_enable = 1'($urandom_range(1));
            ready_pct  = int'($urandom_range(100, 30));
            send_pkt(int'($urandom_range(6, 1)), int'($urandom_range(40, 0)));
        end
        drain();
        check("rand_err_latency", 32'(err_latency), 0);

        // Orphan non-sop beat sets err_framing
        cfg_enable = 1'b0;
        send_beat(16'hBEEF, 1'b0, 1'b0, w);
        drain();
        check("orphan_err_framing", 32'(err_framing), 1);

        // status_clear clears flags and count, winning over a same-cycle eop pop
        send_beat(16'h7777, 1'b1, 1'b1, w);
        snk_valid    = 1'b0;
        status_clear = 1'b1;
        cycle(acc);
        status_clear = 1'b0;
        check("clear_pkt_count",   32'(pkt_count),   0);
        check("clear_err_framing", 32'(err_framing), 0);

        // sop inside a packet sets err_framing
        send_beat(16'h0101, 1'b1, 1'b0, w);
        send_beat(16'h0202, 1'b1, 1'b0, w);
        send_beat(16'h0303, 1'b0, 1'b1, w);
        drain();
        check("sop_in_pkt_err_framing", 32'(err_framing), 1);
        check("pre_late_err_latency",   32'(err_latency), 0);

        // Core result one cycle late sets err_latency; data still follows the delay line
        cfg_enable = 1'b1;
        late_mode  = 1'b1;
        send_beat(16'h5A5B, 1'b1, 1'b1, w);
        drain();
        late_mode = 1'b0;
        idle(2);
        check("late_err_latency", 32'(err_latency), 1);
        status_clear = 1'b1;
        cycle(acc);
        status_clear = 1'b0;
        check("clear2_err_latency", 32'(err_latency), 0);
        check("clear2_err_framing", 32'(err_framing), 0);
        check("clear2_pkt_count",   32'(pkt_count),   0);

        // Reset mid-packet during processed traffic
        cfg_enable = 1'b1;
        send_beat(16'hC001, 1'b1, 1'b0, w);
        send_beat(16'hC002, 1'b0, 1'b0, w);
        snk_data = 16'hC003;
        snk_sop  = 1'b0;
        snk_eop  = 1'b0;
        rst_n    = 1'b0;
        cycle(acc);
        rst_n     = 1'b1;
        snk_valid = 1'b0;
        check("midrst_src_valid",  32'(src_valid),  0);
        check("midrst_proc_valid", 32'(proc_valid), 0);
        idle(PROC_LATENCY + 6);
        check("midrst_fifo_empty",  32'(src_valid),   0);
        check("midrst_err_latency", 32'(err_latency), 0);
        send_pkt(3, 0);
        drain();
        check("midrst_pkt_count", 32'(pkt_count), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
